fir_filter_mc_serial: RTL and testbench
=======================================

// Module: fir_filter_mc_serial
// PURPOSE
//   Multi-channel, time-multiplexed serial FIR. One signed MAC is shared across NUM_CHANNELS interleaved streams.
//   Each channel has its own circular sample history. All channels share one run-time loadable coefficient RAM.
//   Sits between the sample source and the downstream consumer; valid/ready handshake on both sides.
// PARAMETERS
//   DATA_WIDTH    24      sample/output width, signed two's complement
//   COEF_WIDTH    18      coefficient width, signed
//   COEF_FRAC     17      coefficient fractional bits; accumulator is shifted right by this before output
//   TAPS          16      filter length per channel, >=2, power of two
//   NUM_CHANNELS  4       interleaved channels, >=1, power of two
//   ACC_WIDTH     DATA_WIDTH+COEF_WIDTH+$clog2(TAPS)   accumulator width
// PORTS
//   i_clk          in   1             clock, all logic rising-edge
//   i_rst_n        in   1             synchronous reset, active low
//   iv_din         in   DATA_WIDTH    input sample
//   iv_din_ch      in   CH_W          input channel id; CH_W = max(1,$clog2(NUM_CHANNELS))
//   i_din_valid    in   1             input sample valid
//   o_din_ready    out  1             block can accept a sample
//   ov_dout        out  DATA_WIDTH    filtered sample
//   ov_dout_ch     out  CH_W          channel id of ov_dout
//   o_dout_valid   out  1             output valid
//   i_dout_ready   in   1             consumer accepts output
//   i_coef_we      in   1             coefficient write strobe
//   iv_coef_addr   in   $clog2(TAPS)  coefficient index k (h[k])
//   iv_coef_data   in   COEF_WIDTH    coefficient value
//   o_coef_ack     out  1             1-cycle pulse: coefficient write committed
// BEHAVIOUR
//   Reset (i_rst_n=0 at a clock edge):
//   - state=IDLE; o_din_ready=1; o_dout_valid=0; ov_dout=0; ov_dout_ch=0; o_coef_ack=0.
//   - Per-channel write pointers=0 and fill counters=0. Coefficient RAM is NOT cleared.
//   - Reset mid-computation abandons the result; no output is produced for it.
//   Input handshake: a sample is accepted on the edge where i_din_valid && o_din_ready.
//   - o_din_ready=1 only in IDLE.
//   - Channel id >= NUM_CHANNELS: the sample is accepted and dropped; the block stays in IDLE and produces no output.
//   Coefficient port:
//   - A write is committed only in IDLE when no sample is accepted on the same edge; o_coef_ack=1 next cycle.
//   - Same-edge sample accept wins; the write is held off until it can commit; the master holds i_coef_we until ack.
//   - i_coef_we outside IDLE: no write, no ack.
//   FSM: IDLE -> WRITE -> MAC (TAPS cycles) -> DRAIN -> OUT -> IDLE.
//   - Cycle A (IDLE): sample and channel are registered.
//   - A+1 (WRITE): x written to hist[ch][ptr[ch]]; ptr[ch]<=ptr[ch]+1 mod TAPS; fill[ch]<=min(fill[ch]+1,TAPS); acc<=0.
//   - A+2..A+1+TAPS (MAC): read h[k] and x[n-k] for k=0..TAPS-1; the history index wraps modulo TAPS.
//     Reads are synchronous, so each product is accumulated one cycle after its read.
//     Taps with k >= fill[ch] contribute 0, so stale or uninitialised history is never used.
//   - A+2+TAPS (DRAIN): the last product is accumulated.
//   - A+3+TAPS (OUT): o_dout_valid=1, ov_dout and ov_dout_ch are valid. Latency from accept to valid = TAPS+3 cycles.
//   - OUT holds ov_dout, ov_dout_ch and o_dout_valid stable until i_dout_ready=1; IDLE on the following edge.
//   Arithmetic:
//   - Full-precision signed products, signed ACC_WIDTH accumulation, no overflow inside acc.
//   - Output = acc >>> COEF_FRAC (arithmetic shift, truncation toward -inf), then saturated to DATA_WIDTH.
//   - Saturation limits: +2^(DATA_WIDTH-1)-1 and -2^(DATA_WIDTH-1).
//   Channels are fully independent. Interleaving order is arbitrary; repeated samples on one channel are legal.
// TESTING
//   1 Impulse: h[k]=k+1 (COEF_FRAC=0); ch0 gets 1 then 0s -> ch0 outputs 1,2,..,16,0; each valid TAPS+3 cycles after accept.
//   2 Fill masking: after reset, ch2 gets 5 with h=all 1 -> output 5, with no X/stale history; second sample 3 -> 8.
//   3 Interleave: ch0 gets +100s, ch1 gets -100s alternately, h=all 1 -> ch0 ramps 100..1600, ch1 -100..-1600; tags correct.
//   4 Saturation: h=all (2^17-1), COEF_FRAC=17, inputs +max -> ov_dout=+8388607; inputs -max -> -8388608.
//   5 Backpressure: i_dout_ready=0 for 20 cycles -> output stable; o_din_ready=0; coef writes not acked until IDLE.
//   6 Reset: i_rst_n=0 mid-MAC -> no output; next sample on the same channel is treated as the first (fill=0).

Source files
------------

// File: rtl/fir_filter_mc_serial.sv
// Multi-channel time-multiplexed serial FIR filter.
// One shared signed MAC, per-channel circular history, shared coefficient RAM.
module fir_filter_mc_serial #(
  parameter int DATA_WIDTH   = 24,
  parameter int COEF_WIDTH   = 18,
  parameter int COEF_FRAC    = 17,
  parameter int TAPS         = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int ACC_WIDTH    = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS),
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int K_W  = $clog2(TAPS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] iv_din,
  input  logic [CH_W-1:0]       iv_din_ch,
  input  logic                  i_din_valid,
  output logic                  o_din_ready,
  output logic [DATA_WIDTH-1:0] ov_dout,
  output logic [CH_W-1:0]       ov_dout_ch,
  output logic                  o_dout_valid,
  input  logic                  i_dout_ready,
  input  logic                  i_coef_we,
  input  logic [K_W-1:0]        iv_coef_addr,
  input  logic [COEF_WIDTH-1:0] iv_coef_data,
  output logic                  o_coef_ack
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, WRITE, MAC, DRAIN, OUT} state_t;

  state_t                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] x_q, x_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [K_W-1:0]               k_q, k_d;
  logic [K_W-1:0]               ptr_q [NUM_CHANNELS];
  logic [K_W-1:0]               ptr_d [NUM_CHANNELS];
  logic [K_W:0]                 fill_q [NUM_CHANNELS];
  logic [K_W:0]                 fill_d [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [COEF_WIDTH-1:0] h_rd_q, h_rd_d;
  logic signed [DATA_WIDTH-1:0] x_rd_q, x_rd_d;
  logic                         use_q, use_d;
  logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CH_W-1:0]              dout_ch_q, dout_ch_d;
  logic                         ack_q, ack_d;

  logic signed [COEF_WIDTH-1:0] coef_mem [TAPS];
  logic signed [DATA_WIDTH-1:0] hist_mem [NUM_CHANNELS][TAPS];

  logic                         hist_we;
  logic                         coef_we;
  logic                         ch_ok;
  logic [K_W-1:0]               rd_idx;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  shifted;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    ch_d      = ch_q;
    k_d       = k_q;
    ptr_d     = ptr_q;
    fill_d    = fill_q;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    ack_d     = 1'b0;
    hist_we   = 1'b0;
    coef_we   = 1'b0;
    ch_ok     = ({1'b0, iv_din_ch} < (CH_W+1)'(NUM_CHANNELS));
    // newest sample sits one below the (already advanced) write pointer
    rd_idx    = ptr_q[ch_q] - k_q - K_W'(1);
    h_rd_d    = coef_mem[k_q];
    x_rd_d    = hist_mem[ch_q][rd_idx];
    use_d     = (state_q == MAC) && ({1'b0, k_q} < fill_q[ch_q]);
    prod      = PW'(h_rd_q) * PW'(x_rd_q);
    prod_ext  = ACC_WIDTH'(prod);
    acc_d     = use_q ? acc_q + prod_ext : acc_q;
    shifted   = acc_d >>> COEF_FRAC;
    unique case (state_q)
      IDLE: begin
        if (i_din_valid) begin
          if (ch_ok) begin
            x_d     = iv_din;
            ch_d    = iv_din_ch;
            state_d = WRITE;
          end
        end else if (i_coef_we) begin
          coef_we = 1'b1;
          ack_d   = 1'b1;
        end
      end
      WRITE: begin
        hist_we      = 1'b1;
        ptr_d[ch_q]  = ptr_q[ch_q] + K_W'(1);
        if (fill_q[ch_q] != (K_W+1)'(TAPS))
          fill_d[ch_q] = fill_q[ch_q] + (K_W+1)'(1);
        acc_d        = '0;
        k_d          = '0;
        state_d      = MAC;
      end
      MAC: begin
        k_d = k_q + K_W'(1);
        if (k_q == K_W'(TAPS-1))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (shifted > SAT_MAX)
          dout_d = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN)
          dout_d = SAT_MIN[DATA_WIDTH-1:0];
        else
          dout_d = shifted[DATA_WIDTH-1:0];
        dout_ch_d = ch_q;
        state_d   = OUT;
      end
      OUT: begin
        if (i_dout_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      ch_q      <= '0;
      k_q       <= '0;
      ptr_q     <= '{default: '0};
      fill_q    <= '{default: '0};
      acc_q     <= '0;
      use_q     <= 1'b0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      ch_q      <= ch_d;
      k_q       <= k_d;
      ptr_q     <= ptr_d;
      fill_q    <= fill_d;
      acc_q     <= acc_d;
      use_q     <= use_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      ack_q     <= ack_d;
    end
  end

  // storage and read registers carry no reset
  always_ff @(posedge i_clk) begin
    h_rd_q <= h_rd_d;
    x_rd_q <= x_rd_d;
    if (hist_we)
      hist_mem[ch_q][ptr_q[ch_q]] <= x_q;
    if (coef_we)
      coef_mem[iv_coef_addr] <= iv_coef_data;
  end

  assign o_din_ready  = (state_q == IDLE);
  assign o_dout_valid = (state_q == OUT);
  assign ov_dout      = dout_q;
  assign ov_dout_ch   = dout_ch_q;
  assign o_coef_ack   = ack_q;

endmodule

// File: tb/tb_fir_filter_mc_serial.sv
// Directed bench for fir_filter_mc_serial with a scoreboard queue
// fed by a behavioural FIR model.
module tb_fir_filter_mc_serial;

  localparam int DW   = 24;
  localparam int CW   = 18;
  localparam int TAPS = 16;
  localparam int NCH  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic [1:0]    din_ch;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic [1:0]    dout_ch;
  logic          dout_valid;
  logic          dout_ready;
  logic          coef_we;
  logic [3:0]    coef_addr;
  logic [CW-1:0] coef_data;
  logic          coef_ack;

  always #5 clk = ~clk;

  fir_filter_mc_serial dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .iv_din       (din),
    .iv_din_ch    (din_ch),
    .i_din_valid  (din_valid),
    .o_din_ready  (din_ready),
    .ov_dout      (dout),
    .ov_dout_ch   (dout_ch),
    .o_dout_valid (dout_valid),
    .i_dout_ready (dout_ready),
    .i_coef_we    (coef_we),
    .iv_coef_addr (coef_addr),
    .iv_coef_data (coef_data),
    .o_coef_ack   (coef_ack)
  );

  typedef struct {
    logic signed [DW-1:0] d;
    logic [1:0]           ch;
  } exp_t;

  exp_t   sb[$];
  longint coef_m [TAPS];
  longint hist_m [NCH][$];
  int     nchk  = 0;
  int     npass = 0;
  int     nfail = 0;

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] model_out(input int ch);
    longint s = 0;
    for (int k = 0; k < hist_m[ch].size(); k++)
      s += coef_m[k] * hist_m[ch][k];
    s = s >>> 17;
    if (s > 64'sd8388607) s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    return DW'(s);
  endfunction

  task automatic model_push(input int ch, input longint x);
    exp_t e;
    hist_m[ch].push_front(x);
    if (hist_m[ch].size() > TAPS) void'(hist_m[ch].pop_back());
    e.d  = model_out(ch);
    e.ch = 2'(ch);
    sb.push_back(e);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) hist_m[c].delete();
  endtask

  // called at a negedge in IDLE; returns at a negedge
  task automatic wr_coef(input int k, input longint v);
    int n = 0;
    coef_we   = 1'b1;
    coef_addr = 4'(k);
    coef_data = CW'(v);
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (!coef_ack && n < 20);
    chk("coef_ack", coef_ack, 1);
    coef_m[k] = v;
    coef_we = 1'b0;
  endtask

  task automatic do_sample(input int ch, input longint x, input int hold);
    exp_t e;
    int   cyc;
    model_push(ch, x);
    din        = DW'(x);
    din_ch     = 2'(ch);
    din_valid  = 1'b1;
    dout_ready = (hold == 0);
    chk("din_ready_idle", din_ready, 1);
    @(posedge clk); @(negedge clk);
    din_valid = 1'b0;
    cyc = 1;
    while (!dout_valid && cyc < 100) begin
      @(posedge clk); @(negedge clk); cyc++;
    end
    chk("latency", cyc, TAPS + 3);
    e = sb.pop_front();
    chk("dout", $signed(dout), e.d);
    chk("dout_ch", dout_ch, e.ch);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", dout_valid, 1);
      chk("hold_dout", $signed(dout), e.d);
      chk("hold_din_ready", din_ready, 0);
      chk("hold_no_ack", coef_ack, 0);
    end
    dout_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("out_released", dout_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    rst_n      = 1'b0;
    din        = '0;
    din_ch     = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_din_ready", din_ready, 1);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_ch", dout_ch, 0);
    chk("rst_coef_ack", coef_ack, 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    // impulse: h[k]=k+1, unit input scaled by 2^17
    for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
    do_sample(0, 131072, 0);
    for (int i = 0; i < TAPS; i++) do_sample(0, 0, 0);

    // fill masking on a never-used channel
    for (int k = 0; k < TAPS; k++) wr_coef(k, 1);
    do_sample(2, 5 * 131072, 0);
    do_sample(2, 3 * 131072, 0);

    // interleaved ramps
    for (int k = 0; k < TAPS; k++) wr_coef(k, 131071);
    for (int i = 0; i < TAPS; i++) begin
      do_sample(0, 100000, 0);
      do_sample(1, -100000, 0);
    end

    // saturation both ways
    for (int i = 0; i < 3; i++) do_sample(3, 8388607, 0);
    for (int i = 0; i < 6; i++) do_sample(3, -8388608, 0);

    // backpressure with a pending coefficient write
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 18'd5;
    do_sample(1, 12345, 20);
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (!coef_ack && n < 10);
    chk("bp_coef_ack", coef_ack, 1);
    chk("bp_ack_delay", n, 1);
    coef_m[0] = 5;
    coef_we = 1'b0;

    // reset in the middle of MAC
    din       = DW'(1000000);
    din_ch    = 2'd2;
    din_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    din_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("mid_rst_din_ready", din_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (dout_valid) seen++;
    end
    chk("mid_rst_no_output", seen, 0);
    do_sample(2, 7 * 131072, 0);
    do_sample(2, 131072, 0);
    do_sample(0, 2 * 131072, 0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
